// File: rtl/simon_decrypt_control.sv
// SIMON32/64 decryptor: one-time key expansion into a round-key table, then one inverse round per clock (T cycles/block).
// Level requests, one-cycle registered acks; SIMON_DEC_CLEAR_EN zeroes plain while invalid and clears table/block on R.
module simon_decrypt_control #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int C = 5
) (
  input  logic                clk,
  input  logic                R,
  input  logic                newKey,
  input  logic                newData,
  input  logic [M-1:0][N-1:0] key,
  input  logic [2*N-1:0]      cipher,
  output logic                ldKey,
  output logic                ldData,
  output logic                doneKey,
  output logic                doneData,
  output logic [2*N-1:0]      plain
);

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC, S_DONE} state_t;

  localparam logic [61:0]  Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [N-1:0] KC = {{(N-2){1'b1}}, 2'b00};

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  state_t         r_state;
  logic [C-1:0]   r_cnt;
  logic           r_ldKey;
  logic           r_ldData;
  logic           r_doneKey;
  logic           r_doneData;
  logic [N-1:0]   r_tab [T];
  logic [2*N-1:0] r_blk;

  logic           w_req_ok;
  logic           w_key_cap;
  logic           w_dat_cap;
  logic           w_kexp_en;
  logic           w_dec_en;

  assign w_req_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_key_cap = !R && w_req_ok && newKey;
  assign w_dat_cap = !R && w_req_ok && !newKey && newData && r_doneKey;
  assign w_kexp_en = !R && (r_state == S_KEXP);
  assign w_dec_en  = !R && (r_state == S_DEC);

  // Key schedule: r_cnt points at the word being generated, k[i+4] with i = r_cnt - M.
  logic [C-1:0] w_i0;
  logic [C-1:0] w_i1;
  logic [C-1:0] w_i3;
  logic [5:0]   w_zidx;
  logic [N-1:0] w_t;
  logic [N-1:0] w_knew;

  assign w_i0   = r_cnt - C'(M);
  assign w_i1   = r_cnt - C'(M - 1);
  assign w_i3   = r_cnt - C'(1);
  assign w_zidx = 6'd61 - 6'(w_i0);
  assign w_t    = ror(r_tab[w_i3], 3) ^ r_tab[w_i1];
  assign w_knew = KC ^ {{(N-1){1'b0}}, Z0[w_zidx]} ^ r_tab[w_i0] ^ w_t ^ ror(w_t, 1);

  logic [N-1:0]   w_x;
  logic [N-1:0]   w_y;
  logic [N-1:0]   w_fy;
  logic [2*N-1:0] w_inv;

  assign w_x   = r_blk[2*N-1:N];
  assign w_y   = r_blk[N-1:0];
  assign w_fy  = (rol(w_y, 1) & rol(w_y, 8)) ^ rol(w_y, 2);
  assign w_inv = {w_y, w_x ^ w_fy ^ r_tab[r_cnt]};

  always_ff @(posedge clk) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ldKey    <= 1'b0;
      r_ldData   <= 1'b0;
      r_doneKey  <= 1'b0;
      r_doneData <= 1'b0;
    end else begin
      r_ldKey  <= 1'b0;
      r_ldData <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_key_cap) begin
            r_state    <= S_KEXP;
            r_cnt      <= C'(M);
            r_doneKey  <= 1'b0;
            r_doneData <= 1'b0;
            r_ldKey    <= 1'b1;
          end else if (w_dat_cap) begin
            r_state    <= S_DEC;
            r_cnt      <= C'(T - 1);
            r_doneData <= 1'b0;
            r_ldData   <= 1'b1;
          end
        end
        S_KEXP: begin
          r_cnt <= r_cnt + C'(1);
          if (r_cnt == C'(T - 1)) begin
            r_state   <= S_IDLE;
            r_doneKey <= 1'b1;
          end
        end
        S_DEC: begin
          if (r_cnt == '0) begin
            r_state    <= S_DONE;
            r_doneData <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
`ifdef SIMON_DEC_CLEAR_EN
    if (R) begin
      for (int i = 0; i < T; i++) r_tab[i] <= '0;
      r_blk <= '0;
    end else
`endif
    begin
      if (w_key_cap) begin
        for (int i = 0; i < M; i++) r_tab[i] <= key[i];
`ifdef SIMON_DEC_CLEAR_EN
        for (int i = M; i < T; i++) r_tab[i] <= '0;
`endif
      end else if (w_kexp_en) begin
        r_tab[r_cnt] <= w_knew;
      end
      if (w_dat_cap) begin
        r_blk <= cipher;
      end else if (w_dec_en) begin
        r_blk <= w_inv;
      end
    end
  end

  assign ldKey    = r_ldKey;
  assign ldData   = r_ldData;
  assign doneKey  = r_doneKey;
  assign doneData = r_doneData;

`ifdef SIMON_DEC_CLEAR_EN
  assign plain = r_doneData ? r_blk : '0;
`else
  assign plain = r_blk;
`endif

endmodule

// File: tb/tb_simon_decrypt_control.sv
// Bench for simon_decrypt_control: known-answer SIMON32/64 vector plus random key/plaintext pairs.
module tb_simon_decrypt_control;
  localparam int T = 32;
  localparam logic [63:0] KV  = 64'h1918_1110_0908_0100;
  localparam logic [31:0] CV  = 32'hc69be9bb;
  localparam logic [31:0] PV  = 32'h65656877;

  logic             clk;
  logic             R;
  logic             newKey;
  logic             newData;
  logic [3:0][15:0] key;
  logic [31:0]      cipher;
  logic             ldKey;
  logic             ldData;
  logic             doneKey;
  logic             doneData;
  logic [31:0]      plain;

  int total;
  int bad;
  logic [15:0] mk [T];
  string z0 = "11111010001001010110000111001101111101000100101011000011100110";

  simon_decrypt_control dut (
    .clk(clk), .R(R), .newKey(newKey), .newData(newData), .key(key), .cipher(cipher),
    .ldKey(ldKey), .ldData(ldData), .doneKey(doneKey), .doneData(doneData), .plain(plain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] fsim(input logic [15:0] v);
    return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
  endfunction

  task automatic expand(input logic [63:0] k);
    logic [15:0] t;
    logic [15:0] z;
    for (int i = 0; i < 4; i++) mk[i] = k[16*i +: 16];
    for (int i = 0; i < T - 4; i++) begin
      t = ror16(mk[i+3], 3) ^ mk[i+1];
      z = (z0[i % 62] == 8'h31) ? 16'd1 : 16'd0;
      mk[i+4] = 16'hFFFC ^ z ^ mk[i] ^ t ^ ror16(t, 1);
    end
  endtask

  function automatic logic [31:0] encrypt(input logic [31:0] p);
    logic [15:0] x, y, tmp;
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < T; i++) begin
      tmp = x;
      x = y ^ fsim(x) ^ mk[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] inv_round(input logic [31:0] b, input logic [15:0] k);
    return {b[15:0], b[31:16] ^ fsim(b[15:0]) ^ k};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load_key(input logic [63:0] k, output bit ok);
    bit acked;
    acked = 1'b0;
    ok = 1'b0;
    key = k;
    newKey = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (ldKey) begin acked = 1'b1; break; end
    end
    newKey = 1'b0;
    if (acked) begin
      for (int i = 0; i < 40; i++) begin
        tick;
        if (doneKey) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic do_decrypt(input logic [31:0] c, output bit ok, output logic [31:0] got);
    bit acked;
    acked = 1'b0;
    ok = 1'b0;
    got = '0;
    cipher = c;
    newData = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (ldData) begin acked = 1'b1; break; end
    end
    newData = 1'b0;
    if (acked) begin
      for (int i = 0; i < 40; i++) begin
        tick;
        if (doneData) begin ok = 1'b1; got = plain; break; end
      end
    end
  endtask

  task automatic test_reset;
    R = 1'b1; newKey = 1'b0; newData = 1'b0; key = '0; cipher = '0;
    repeat (3) tick;
    total++; if (ldKey !== 1'b0 || ldData !== 1'b0) begin bad++; $display("FAIL reset_acks_in_R got=%b%b want=00", ldKey, ldData); end
    R = 1'b0;
    tick;
    total++; if (doneKey !== 1'b0) begin bad++; $display("FAIL reset_doneKey got=%b want=0", doneKey); end
    total++; if (doneData !== 1'b0) begin bad++; $display("FAIL reset_doneData got=%b want=0", doneData); end
    total++; if (ldKey !== 1'b0 || ldData !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b want=00", ldKey, ldData); end
`ifdef SIMON_DEC_CLEAR_EN
    total++; if (plain !== 32'h0) begin bad++; $display("FAIL reset_plain got=%h want=0", plain); end
`endif
  endtask

  task automatic test_key_load;
    bit acked;
    acked = 1'b0;
    expand(KV);
    key = KV;
    newKey = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ldKey) begin acked = 1'b1; break; end
    end
    newKey = 1'b0;
    total++; if (!acked) begin bad++; $display("FAIL key_ack got=none want=ldKey"); end
    tick;
    total++; if (ldKey !== 1'b0) begin bad++; $display("FAIL key_ack_width got=%b want=0", ldKey); end
    repeat (26) tick;
    total++; if (doneKey !== 1'b0) begin bad++; $display("FAIL key_done_early got=%b want=0", doneKey); end
    tick;
    total++; if (doneKey !== 1'b1) begin bad++; $display("FAIL key_done_28 got=%b want=1", doneKey); end
    total++; if (dut.r_tab[T-1] !== mk[T-1]) begin bad++; $display("FAIL key_table31 got=%h want=%h", dut.r_tab[T-1], mk[T-1]); end
  endtask

  task automatic test_decrypt;
    bit acked;
    logic [31:0] first;
    acked = 1'b0;
    first = inv_round(CV, mk[T-1]);
    cipher = CV;
    newData = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ldData) begin acked = 1'b1; break; end
    end
    newData = 1'b0;
    total++; if (!acked) begin bad++; $display("FAIL dec_ack got=none want=ldData"); end
    tick;
    total++; if (ldData !== 1'b0) begin bad++; $display("FAIL dec_ack_width got=%b want=0", ldData); end
`ifdef SIMON_DEC_CLEAR_EN
    total++; if (plain !== 32'h0) begin bad++; $display("FAIL dec_gated_plain got=%h want=0", plain); end
`else
    total++; if (plain !== first) begin bad++; $display("FAIL dec_round1_plain got=%h want=%h", plain, first); end
`endif
    repeat (30) tick;
    total++; if (doneData !== 1'b0) begin bad++; $display("FAIL dec_done_early got=%b want=0", doneData); end
    tick;
    total++; if (doneData !== 1'b1) begin bad++; $display("FAIL dec_done_32 got=%b want=1", doneData); end
    total++; if (plain !== PV) begin bad++; $display("FAIL dec_plain got=%h want=%h", plain, PV); end
    repeat (5) tick;
    total++; if (doneData !== 1'b1 || plain !== PV) begin bad++; $display("FAIL dec_hold got=%b/%h want=1/%h", doneData, plain, PV); end
  endtask

  task automatic test_priority;
    bit acked;
    acked = 1'b0;
    R = 1'b1; tick; R = 1'b0;
    key = KV; cipher = CV;
    newKey = 1'b1; newData = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ldKey || ldData) begin acked = 1'b1; break; end
    end
    newKey = 1'b0;
    total++; if (!acked || ldKey !== 1'b1 || ldData !== 1'b0) begin bad++; $display("FAIL prio_first_ack got=key%b data%b want=key1 data0", ldKey, ldData); end
    repeat (28) tick;
    total++; if (doneKey !== 1'b1 || ldData !== 1'b0) begin bad++; $display("FAIL prio_keydone got=done%b ld%b want=done1 ld0", doneKey, ldData); end
    tick;
    total++; if (ldData !== 1'b1) begin bad++; $display("FAIL prio_data_ack got=%b want=1", ldData); end
    newData = 1'b0;
    repeat (32) tick;
    total++; if (doneData !== 1'b1 || plain !== PV) begin bad++; $display("FAIL prio_plain got=%b/%h want=1/%h", doneData, plain, PV); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p [3];
    logic [31:0] c [3];
    bit acked;
    acked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p[k] = $urandom;
      c[k] = encrypt(p[k]);
    end
    cipher = c[0];
    newData = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ldData) begin acked = 1'b1; break; end
    end
    total++; if (!acked) begin bad++; $display("FAIL b2b_first_ack got=none want=ldData"); end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) cipher = c[k+1];
      else newData = 1'b0;
      repeat (31) tick;
      total++; if (doneData !== 1'b0) begin bad++; $display("FAIL b2b_early_%0d got=%b want=0", k, doneData); end
      tick;
      total++; if (doneData !== 1'b1 || plain !== p[k]) begin bad++; $display("FAIL b2b_plain_%0d got=%b/%h want=1/%h", k, doneData, plain, p[k]); end
      if (k < 2) begin
        tick;
        total++; if (ldData !== 1'b1 || doneData !== 1'b0) begin bad++; $display("FAIL b2b_recapture_%0d got=ld%b done%b want=ld1 done0", k, ldData, doneData); end
      end
    end
  endtask

  task automatic test_reset_abort;
    bit acked;
    int acks;
    acked = 1'b0;
    acks = 0;
    cipher = CV;
    newData = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ldData) begin acked = 1'b1; break; end
    end
    newData = 1'b0;
    repeat (10) tick;
    R = 1'b1;
    tick;
    R = 1'b0;
    total++; if (!acked || doneKey !== 1'b0 || doneData !== 1'b0) begin bad++; $display("FAIL abort_flags got=ack%b key%b data%b want=ack1 key0 data0", acked, doneKey, doneData); end
    newData = 1'b1;
    repeat (40) begin
      tick;
      if (ldData) acks++;
    end
    newData = 1'b0;
    total++; if (acks !== 0) begin bad++; $display("FAIL abort_no_key_ack got=%0d want=0", acks); end
  endtask

  task automatic test_random;
    logic [63:0] k;
    logic [31:0] p, c, got;
    bit ok_k, ok_d;
    for (int n = 0; n < 200; n++) begin
      k = {$urandom, $urandom};
      p = $urandom;
      expand(k);
      c = encrypt(p);
      do_load_key(k, ok_k);
      do_decrypt(c, ok_d, got);
      total++;
      if (!ok_k || !ok_d || got !== p) begin
        bad++;
        $display("FAIL random_%0d got=%h want=%h handshake=%b%b", n, got, p, ok_k, ok_d);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_key_load;
    test_decrypt;
    test_priority;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
